hi_reader_15_seq: RTL and testbench
===================================

// Module: hi_reader_15_seq
// PURPOSE
//   Transaction sequencer for the hi_reader_15 datapath. Drives its minor_mode and
//   ssp_dout inputs through one reader exchange: modulated TX, guard, listen, RX.
//   Serialises ARM-supplied bits into BIT_CYCLES-long modulation slots.
//   Ends the exchange on tag silence, timeout, TX underrun or abort.
//   Sits between the ARM command interface and hi_reader_15, in the ck_1356meg domain.
// PARAMETERS
//   BIT_CYCLES      128    ck_1356meg cycles per TX bit slot (1..65535)
//   GUARD_CYCLES    1024   post-TX cycles in which rx_activity is ignored (1..65535)
//   TIMEOUT_CYCLES  40000  max LISTEN cycles awaiting a tag response (1..65535)
//   QUIET_CYCLES    512    consecutive inactive RX cycles that end the response (1..65535)
// PORTS
//   ck_1356meg    in   1  13.56 MHz clock; all logic on negedge, like hi_reader_15
//   rst           in   1  synchronous reset, active-high
//   start         in   1  begin exchange; honoured only in IDLE
//   abort         in   1  end exchange now; highest priority
//   tx_mod_mode   in   4  minor mode during TX (SEND_FULL_MOD or SEND_SHALLOW_MOD)
//   rx_mode       in   4  minor mode outside TX (e.g. RECEIVE_AMPLITUDE)
//   tx_bit        in   1  next bit to send (1 = modulate)
//   tx_bit_valid  in   1  tx_bit/tx_last valid
//   tx_last       in   1  marks final bit of frame
//   tx_bit_ready  out  1  one-cycle pulse: bit is accepted this cycle if valid
//   rx_activity   in   1  tag activity (amplitude over threshold or fskout != 0)
//   minor_mode    out  4  to hi_reader_15 minor_mode
//   ssp_dout_mod  out  1  to hi_reader_15 ssp_dout
//   busy          out  1  high in every state except IDLE
//   done          out  1  one-cycle pulse at end of exchange
//   status        out  2  valid with done, held until next done: 00 OK, 01 TIMEOUT, 10 UNDERRUN, 11 ABORT
//   state_dbg     out  3  current state encoding
// BEHAVIOUR
//   - Reset: state IDLE, minor_mode=rx_mode, ssp_dout_mod=0, tx_bit_ready=0.
//     Also busy=0, done=0, status=00, all counters 0. Reset wins over abort/start.
//   - All outputs registered. minor_mode follows the state one cycle after the transition.
//   - States and codes: IDLE 0, TX 1, GUARD 2, LISTEN 3, RX 4, DONE 5.
//   - IDLE: minor_mode=rx_mode (carrier on). start=1 and abort=0 -> TX next cycle.
//   - TX: minor_mode=tx_mod_mode. First TX cycle and each slot boundary is a load cycle.
//     In a load cycle, tx_bit_ready=1.
//     Valid=1 in load cycle: latch bit; ssp_dout_mod=bit for the next BIT_CYCLES cycles.
//     Valid=0 in load cycle: DONE with status UNDERRUN, ssp_dout_mod=0.
//     After the slot of a bit accepted with tx_last=1, go to GUARD with ssp_dout_mod=0.
//   - GUARD: minor_mode=rx_mode; GUARD_CYCLES cycles, rx_activity ignored; then LISTEN.
//   - LISTEN: rx_activity=1 -> RX. TIMEOUT_CYCLES cycles elapse with no activity -> DONE, TIMEOUT.
//     Activity on the expiry cycle -> RX (activity wins).
//   - RX: quiet counter cleared on each rx_activity=1 cycle.
//     QUIET_CYCLES consecutive inactive cycles -> DONE, status OK. No RX length limit.
//   - DONE: one cycle; done=1, status updated; busy=1; then IDLE.
//     A start asserted during DONE is ignored.
//   - abort=1 in TX/GUARD/LISTEN/RX -> DONE next cycle, status ABORT.
//     ssp_dout_mod=0 immediately; counters cleared. abort in IDLE or DONE: no effect.
//     abort with start in IDLE: start ignored.
//   - start while busy: ignored, no queuing.
//   - Counters: 16-bit unsigned, cleared on every state entry, saturate (never wrap).
// TESTING
//   - Reset: rst held 3 cycles mid-TX -> IDLE, ssp_dout_mod=0, busy=0, status=00.
//     Check on the cycle after rst deasserts.
//   - 3-bit frame 1,0,1 (last on 3rd), BIT_CYCLES=4, always valid:
//     ssp_dout_mod = 1111 0000 1111. minor_mode=tx_mod_mode for exactly 12 cycles.
//     Exactly 3 tx_bit_ready pulses, 4 cycles apart.
//   - No response, TIMEOUT_CYCLES=100: done at TX end + GUARD_CYCLES + 100 (+/-1 cycle), status=01.
//   - Response: activity 50 cycles, then quiet, QUIET_CYCLES=16 -> done 16 cycles after last activity.
//     status=00. Activity during GUARD has no effect.
//   - Underrun: tx_bit_valid dropped at 2nd load cycle -> done next cycle, status=10, ssp_dout_mod=0.
//   - Abort in LISTEN together with rx_activity -> DONE, status=11, not RX.
//     start in the same cycle as done -> stays IDLE.

Source files
------------

// File: rtl/hi_reader_15_seq_if.sv
// ============================================================================
// Module      : hi_reader_15_seq_if
// Description : ARM-side command and TX bit-stream handshake bundle for the
//               hi_reader_15 transaction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hi_reader_15_seq_if;
    // Exchange control
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [1:0] status;

    // TX bit stream: the bit is taken in any cycle where ready and valid are both high
    logic       tx_bit;
    logic       tx_bit_valid;
    logic       tx_last;
    logic       tx_bit_ready;

    // ARM / command side
    modport master (
        output start, abort, tx_bit, tx_bit_valid, tx_last,
        input  tx_bit_ready, busy, done, status
    );

    // Sequencer side
    modport slave (
        input  start, abort, tx_bit, tx_bit_valid, tx_last,
        output tx_bit_ready, busy, done, status
    );
endinterface

`default_nettype wire

// File: rtl/hi_reader_15_seq.sv
// ============================================================================
// Module      : hi_reader_15_seq
// Description : Reader exchange sequencer for hi_reader_15. Walks one exchange
//               (TX -> GUARD -> LISTEN -> RX -> DONE), serialising ARM bits into
//               BIT_CYCLES-long modulation slots and steering minor_mode.
//               All logic runs on the falling edge of ck_1356meg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hi_reader_15_seq #(
    parameter int unsigned BIT_CYCLES     = 128,
    parameter int unsigned GUARD_CYCLES   = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 40000,
    parameter int unsigned QUIET_CYCLES   = 512
) (
    input  wire logic         ck_1356meg,
    input  wire logic         rst,
    hi_reader_15_seq_if.slave cmd,
    input  wire logic [3:0]   tx_mod_mode,
    input  wire logic [3:0]   rx_mode,
    input  wire logic         rx_activity,
    output logic [3:0]        minor_mode,
    output logic              ssp_dout_mod,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TX     = 3'd1,
        S_GUARD  = 3'd2,
        S_LISTEN = 3'd3,
        S_RX     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [1:0]  c_ST_OK       = 2'b00;
    localparam logic [1:0]  c_ST_TIMEOUT  = 2'b01;
    localparam logic [1:0]  c_ST_UNDERRUN = 2'b10;
    localparam logic [1:0]  c_ST_ABORT    = 2'b11;

    // Terminal counts: each phase lasts exactly N cycles, counter runs 0..N-1
    localparam logic [15:0] c_BIT_END     = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] c_GUARD_END   = 16'(GUARD_CYCLES - 1);
    localparam logic [15:0] c_TIMEOUT_END = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] c_QUIET_END   = 16'(QUIET_CYCLES - 1);

    state_t      r_state_q;
    logic [15:0] r_cnt_q;
    logic        r_last_q;
    logic [3:0]  r_minor_mode_q;
    logic        r_ssp_q;
    logic        r_ready_q;
    logic        r_busy_q;
    logic        r_done_q;
    logic [1:0]  r_status_q;

    state_t      w_state_d;
    logic [15:0] w_cnt_d;
    logic [15:0] w_cnt_inc;
    logic        w_last_d;
    logic [3:0]  w_minor_mode_d;
    logic        w_ssp_d;
    logic        w_ready_d;
    logic        w_busy_d;
    logic        w_done_d;
    logic [1:0]  w_status_d;
    logic        w_load;
    logic        w_slot_last;

    // Next-state, counter and registered-output computation
    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_inc   = (r_cnt_q == 16'hFFFF) ? r_cnt_q : r_cnt_q + 16'd1;
        w_cnt_d     = w_cnt_inc;
        w_last_d    = r_last_q;
        w_ssp_d     = 1'b0;
        w_status_d  = r_status_q;
        w_load      = (r_state_q == S_TX) && (r_cnt_q == 16'd0);
        // With BIT_CYCLES=1 the load and slot-end cycles coincide, so use the live flag
        w_slot_last = w_load ? cmd.tx_last : r_last_q;

        case (r_state_q)
            S_IDLE: begin
                w_cnt_d = 16'd0;
                if (cmd.start && !cmd.abort) begin
                    w_state_d = S_TX;
                end
            end
            S_TX: begin
                if (cmd.abort) begin
                    w_state_d  = S_DONE;
                    w_status_d = c_ST_ABORT;
                end else if (w_load && !cmd.tx_bit_valid) begin
                    w_state_d  = S_DONE;
                    w_status_d = c_ST_UNDERRUN;
                end else begin
                    w_ssp_d = w_load ? cmd.tx_bit : r_ssp_q;
                    if (w_load) begin
                        w_last_d = cmd.tx_last;
                    end
                    if (r_cnt_q == c_BIT_END) begin
                        // Slot boundary: next cycle is a load cycle or the frame is over
                        w_cnt_d = 16'd0;
                        if (w_slot_last) begin
                            w_state_d = S_GUARD;
                        end
                    end
                end
            end
            S_GUARD: begin
                if (cmd.abort) begin
                    w_state_d  = S_DONE;
                    w_status_d = c_ST_ABORT;
                end else if (r_cnt_q == c_GUARD_END) begin
                    w_state_d = S_LISTEN;
                end
            end
            S_LISTEN: begin
                // Activity on the expiry cycle still counts as a response
                if (cmd.abort) begin
                    w_state_d  = S_DONE;
                    w_status_d = c_ST_ABORT;
                end else if (rx_activity) begin
                    w_state_d = S_RX;
                end else if (r_cnt_q == c_TIMEOUT_END) begin
                    w_state_d  = S_DONE;
                    w_status_d = c_ST_TIMEOUT;
                end
            end
            S_RX: begin
                if (cmd.abort) begin
                    w_state_d  = S_DONE;
                    w_status_d = c_ST_ABORT;
                end else if (rx_activity) begin
                    w_cnt_d = 16'd0;
                end else if (r_cnt_q == c_QUIET_END) begin
                    w_state_d  = S_DONE;
                    w_status_d = c_ST_OK;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Every state entry starts its phase counter from zero
        if (w_state_d != r_state_q) begin
            w_cnt_d = 16'd0;
        end

        // minor_mode trails the state by one cycle, in step with ssp_dout_mod
        w_minor_mode_d = (r_state_q == S_TX) ? tx_mod_mode : rx_mode;
        // ready must be high during the load cycle itself, so it looks ahead
        w_ready_d      = (w_state_d == S_TX) && (w_cnt_d == 16'd0);
        w_busy_d       = (w_state_d != S_IDLE);
        w_done_d       = (w_state_d == S_DONE);
    end

    // State and output registers, falling edge like the hi_reader_15 datapath
    always_ff @(negedge ck_1356meg) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_cnt_q        <= 16'd0;
            r_last_q       <= 1'b0;
            r_minor_mode_q <= rx_mode;
            r_ssp_q        <= 1'b0;
            r_ready_q      <= 1'b0;
            r_busy_q       <= 1'b0;
            r_done_q       <= 1'b0;
            r_status_q     <= c_ST_OK;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_last_q       <= w_last_d;
            r_minor_mode_q <= w_minor_mode_d;
            r_ssp_q        <= w_ssp_d;
            r_ready_q      <= w_ready_d;
            r_busy_q       <= w_busy_d;
            r_done_q       <= w_done_d;
            r_status_q     <= w_status_d;
        end
    end

    assign minor_mode       = r_minor_mode_q;
    assign ssp_dout_mod     = r_ssp_q;
    assign state_dbg        = r_state_q;
    assign cmd.tx_bit_ready = r_ready_q;
    assign cmd.busy         = r_busy_q;
    assign cmd.done         = r_done_q;
    assign cmd.status       = r_status_q;

endmodule

`default_nettype wire

// File: tb/tb_hi_reader_15_seq.sv
// ============================================================================
// Module      : tb_hi_reader_15_seq
// Description : Self-checking bench for hi_reader_15_seq. Each exchange is
//               described by its frame and RX/abort/underrun scenario; the
//               expected waveform and end point are derived from the phase
//               lengths with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hi_reader_15_seq;
    localparam int B  = 4;
    localparam int G  = 20;
    localparam int TO = 100;
    localparam int Q  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tx_mod_mode;
    logic [3:0] rx_mode;
    logic       rx_activity;
    logic [3:0] minor_mode;
    logic       ssp_dout_mod;
    logic [2:0] state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    hi_reader_15_seq_if bus ();

    hi_reader_15_seq #(
        .BIT_CYCLES     (B),
        .GUARD_CYCLES   (G),
        .TIMEOUT_CYCLES (TO),
        .QUIET_CYCLES   (Q)
    ) dut (
        .ck_1356meg   (clk),
        .rst          (rst),
        .cmd          (bus.slave),
        .tx_mod_mode  (tx_mod_mode),
        .rx_mode      (rx_mode),
        .rx_activity  (rx_activity),
        .minor_mode   (minor_mode),
        .ssp_dout_mod (ssp_dout_mod),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.tx_bit       = 1'b0;
        bus.tx_bit_valid = 1'b0;
        bus.tx_last      = 1'b0;
        rx_activity      = 1'b0;
    endtask

    // Cycle 0 is the IDLE cycle carrying start; TX occupies cycles 1..N*B,
    // GUARD starts at tg = 1+N*B, LISTEN at tl = tg+G.
    // resp_off < 0: no tag response; under_idx < 0: no underrun; abort_at <= 0: no abort.
    task automatic run_exchange(input int nbits, input logic [15:0] bits,
                                input int resp_off, input int resp_len, input bit guard_act,
                                input int under_idx, input int abort_at, input bit start_on_done);
        int tg, tl, lo, hi, lim, k, done_n, ndone, nready, exp_ready, ssp_hi, mm_hi;
        logic [1:0] exp_st, st_at_done;
        bit exact, ready_exp, ssp_exp;
        tg = 1 + nbits * B;
        tl = tg + G;
        exact = 1'b1;
        exp_ready = nbits;
        if (under_idx >= 0) begin
            lo = 2 + under_idx * B; exp_st = 2'b10; exp_ready = under_idx + 1;
        end else if (abort_at > 0) begin
            lo = abort_at + 1;      exp_st = 2'b11;
            if (abort_at < tg) exp_ready = (nbits < (abort_at - 1) / B + 1) ? nbits : (abort_at - 1) / B + 1;
        end else if (resp_off >= 0) begin
            exact = 1'b0; exp_st = 2'b00;
            lo = tl + resp_off + resp_len - 1 + Q;  // last active cycle + Q quiet cycles
        end else begin
            exact = 1'b0; exp_st = 2'b01;
            lo = tl + TO - 1;
        end
        hi  = exact ? lo : lo + (resp_off >= 0 ? 1 : 2);
        lim = exact ? lo : 32'h3FFF_FFFF;
        ssp_hi = (tg < lim - 1) ? tg : lim - 1;
        mm_hi  = (tg < lim) ? tg : lim;
        k = 0; done_n = -1; ndone = 0; nready = 0; st_at_done = 2'bxx;

        @(posedge clk);
        idle_inputs();
        bus.start = 1'b1;
        for (int n = 1; n <= 1500; n++) begin
            @(posedge clk);
            ready_exp = (n < lim) && ((n - 1) % B == 0) && ((n - 1) / B < nbits);
            ssp_exp   = (n >= 2 && n <= ssp_hi) ? bits[(n - 2) / B] : 1'b0;
            check("tx_bit_ready", bus.tx_bit_ready, ready_exp);
            check("ssp_dout_mod", ssp_dout_mod, ssp_exp);
            check("minor_mode", minor_mode, (n >= 2 && n <= mm_hi) ? tx_mod_mode : rx_mode);
            if (n <= lo) check("busy", bus.busy, 1);
            if (n == 1) check("state_tx", state_dbg, 1);
            if (n == tg && tg < lim) check("state_guard", state_dbg, 2);
            if (n == tl && tl < lim) check("state_listen", state_dbg, 3);
            if (!exact && resp_off >= 0 && n == tl + resp_off + 1) check("state_rx", state_dbg, 4);
            if (exact && n == lim) check("state_done", state_dbg, 5);
            if (done_n >= 0 && n > done_n) check("idle_after_done", state_dbg, 0);
            if (bus.tx_bit_ready) nready++;
            if (bus.done) begin
                if (done_n < 0) begin
                    done_n = n;
                    st_at_done = bus.status;
                end
                ndone++;
            end
            // inputs for cycle n
            bus.start        = start_on_done && bus.done;
            bus.abort        = (n == abort_at);
            bus.tx_bit_valid = (k < nbits) && (k != under_idx);
            bus.tx_bit       = (k < nbits) ? bits[k] : 1'b0;
            bus.tx_last      = (k == nbits - 1);
            rx_activity      = (resp_off >= 0 && n >= tl + resp_off && n < tl + resp_off + resp_len)
                             || (guard_act && n >= tg + 2 && n < tg + 6);
            if (bus.tx_bit_ready && bus.tx_bit_valid) k++;
            if (done_n >= 0 && n >= done_n + 3) break;
        end
        idle_inputs();
        n_assert++;
        assert (done_n >= lo && done_n <= hi) else begin
            n_fail++;
            $error("FAIL done_cycle: observed %0d expected %0d..%0d", done_n, lo, hi);
        end
        check("status", st_at_done, exp_st);
        check("status_held", bus.status, exp_st);
        check("done_pulses", ndone, 1);
        check("ready_pulses", nready, exp_ready);
        check("busy_after", bus.busy, 0);
        check("idle_after", state_dbg, 0);
    endtask

    initial begin
        int mode, nb, ro, rl, ua, ab;
        logic [15:0] bits;
        rst = 1'b1;
        tx_mod_mode = 4'd1;
        rx_mode     = 4'd3;
        idle_inputs();
        repeat (3) @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        check("rst_state", state_dbg, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_status", bus.status, 0);
        check("rst_ssp", ssp_dout_mod, 0);
        check("rst_ready", bus.tx_bit_ready, 0);
        check("rst_minor", minor_mode, rx_mode);

        // Frame 1,0,1 answered by 50 active cycles; GUARD activity must be ignored
        run_exchange(3, 16'b101, 5, 50, 1'b1, -1, 0, 1'b1);
        // No tag response
        tx_mod_mode = 4'd2; rx_mode = 4'd4;
        run_exchange(4, 16'b0110, -1, 0, 1'b0, -1, 0, 1'b0);
        // ARM fails to supply the second bit
        run_exchange(3, 16'b111, -1, 0, 1'b0, 1, 0, 1'b0);
        // Abort in LISTEN on the same cycle as the first tag activity; start with done
        run_exchange(2, 16'b01, 3, 10, 1'b0, -1, 1 + 2 * B + G + 3, 1'b1);

        // Reset in the middle of TX wipes the ABORT status
        @(posedge clk);
        bus.start = 1'b1; bus.tx_bit_valid = 1'b1; bus.tx_bit = 1'b1; bus.tx_last = 1'b0;
        @(posedge clk);
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        check("pre_rst_ssp", ssp_dout_mod, 1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        check("midtx_rst_state", state_dbg, 0);
        check("midtx_rst_ssp", ssp_dout_mod, 0);
        check("midtx_rst_busy", bus.busy, 0);
        check("midtx_rst_status", bus.status, 0);
        check("midtx_rst_minor", minor_mode, rx_mode);

        // Randomized exchanges
        for (int i = 0; i < 8; i++) begin
            mode = int'($urandom_range(0, 3));
            nb   = int'($urandom_range(1, 6));
            bits = 16'($urandom);
            tx_mod_mode = 4'($urandom);
            rx_mode     = 4'($urandom);
            @(posedge clk);
            case (mode)
                0: begin
                    ro = int'($urandom_range(0, 40));
                    rl = int'($urandom_range(1, 60));
                    run_exchange(nb, bits, ro, rl, 1'($urandom), -1, 0, 1'($urandom));
                end
                1: run_exchange(nb, bits, -1, 0, 1'($urandom), -1, 0, 1'($urandom));
                2: begin
                    ua = int'($urandom_range(0, nb - 1));
                    run_exchange(nb, bits, -1, 0, 1'b0, ua, 0, 1'($urandom));
                end
                default: begin
                    ab = int'($urandom_range(1, 1 + nb * B + G + 10));
                    run_exchange(nb, bits, -1, 0, 1'($urandom), -1, ab, 1'($urandom));
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
